// File: rtl/commit_trace_fifo.sv
// Commit/event/memory trace packer feeding a first-word-fall-through record FIFO.
// Overflow drops records but exposes every loss through sequence gaps and sticky status.
module commit_trace_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SEQ_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     commit_valid,
    input  logic [31:0]              commit_pc,
    input  logic [31:0]              commit_inst,
    input  logic [4:0]               commit_rd_addr,
    input  logic [31:0]              commit_rd_wdata,
    input  logic                     mem_valid,
    input  logic                     mem_write,
    input  logic [31:0]              mem_addr,
    input  logic [6:0]               mem_width,
    input  logic [31:0]              mem_data,
    input  logic                     event_valid,
    input  logic [31:0]              event_cause,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [SEQ_W-1:0]         rec_seq,
    output logic [3:0]               rec_flags,
    output logic [31:0]              rec_pc,
    output logic [31:0]              rec_inst,
    output logic [4:0]               rec_rd_addr,
    output logic [31:0]              rec_rd_wdata,
    output logic [31:0]              rec_mem_addr,
    output logic [6:0]               rec_mem_width,
    output logic [31:0]              rec_mem_data,
    output logic [31:0]              rec_cause,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [SEQ_W-1:0]         drop_count,
    input  logic                     clear_status
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [3:0]       flags;
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [4:0]       rd_addr;
        logic [31:0]      rd_wdata;
        logic [31:0]      mem_addr;
        logic [6:0]       mem_width;
        logic [31:0]      mem_data;
        logic [31:0]      cause;
    } rec_t;

    rec_t             entries [DEPTH];
    rec_t             new_rec;
    rec_t             head;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [SEQ_W-1:0] seq_cnt;
    logic             push_req;
    logic             pop;
    logic             full;
    logic             accept;
    logic             drop;

    assign push_req = commit_valid | event_valid;
    assign rec_valid = (level != '0);
    assign pop      = rec_valid & rec_ready;
    assign full     = (level == LW'(DEPTH));
    assign accept   = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // Record assembly: commit-side fields only when an instruction retired.
    always_comb begin
        new_rec           = '0;
        new_rec.seq       = seq_cnt;
        new_rec.flags[0]  = commit_valid;
        new_rec.flags[3]  = event_valid;
        if (commit_valid) begin
            new_rec.flags[1]  = mem_valid;
            new_rec.flags[2]  = mem_write;
            new_rec.pc        = commit_pc;
            new_rec.inst      = commit_inst;
            new_rec.rd_addr   = commit_rd_addr;
            new_rec.rd_wdata  = (commit_rd_addr != 5'd0) ? commit_rd_wdata : 32'd0;
            new_rec.mem_addr  = mem_addr;
            new_rec.mem_width = mem_width;
            new_rec.mem_data  = mem_data;
        end
        if (event_valid) begin
            new_rec.cause = event_cause;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
        end else if (accept) begin
            entries[wr_ptr] <= new_rec;
        end
    end

    // Pointers, occupancy and sequence counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            seq_cnt <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (accept && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !accept) begin
                level <= level - LW'(1);
            end
            if (push_req) begin
                seq_cnt <= seq_cnt + SEQ_W'(1);
            end
        end
    end

    // Sticky loss status; a drop in the same cycle overrides a clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_status) begin
                drop_count <= SEQ_W'(1);
            end else if (drop_count != '1) begin
                drop_count <= drop_count + SEQ_W'(1);
            end
        end else if (clear_status) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    assign head          = rec_valid ? entries[rd_ptr] : '0;
    assign rec_seq       = head.seq;
    assign rec_flags     = head.flags;
    assign rec_pc        = head.pc;
    assign rec_inst      = head.inst;
    assign rec_rd_addr   = head.rd_addr;
    assign rec_rd_wdata  = head.rd_wdata;
    assign rec_mem_addr  = head.mem_addr;
    assign rec_mem_width = head.mem_width;
    assign rec_mem_data  = head.mem_data;
    assign rec_cause     = head.cause;

endmodule

// File: doc/commit_trace_fifo.md
Name: commit_trace_fifo

Overview:
- Downstream consumer of the core's commit/event/memory observation port.
- Each cycle with a commit or trap/interrupt event, the block packs one trace record:
  - commit fields (pc, inst, rd write);
  - the accompanying data-memory access;
  - event info;
  - a sequence number.
- Records are queued in a first-word-fall-through FIFO and handed to the reference-model checker over a valid/ready handshake.
- Overflow drops records but never silently: sequence gaps and sticky status make every loss visible.

Parameters:
- DEPTH, 8, number of record entries; power of two, ≥2.
- SEQ_W, 32, width of the sequence number and of the drop counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- commit_valid  in  1  instruction retired this cycle.
- commit_pc  in  32  PC of retired instruction.
- commit_inst  in  32  instruction word.
- commit_rd_addr  in  5  destination register; 0 = no write.
- commit_rd_wdata  in  32  destination write data.
- mem_valid  in  1  data access associated with this commit.
- mem_write  in  1  1 = store, 0 = load.
- mem_addr  in  32  access address.
- mem_width  in  7  access width in bits: 8, 16 or 32.
- mem_data  in  32  store data or load data.
- event_valid  in  1  trap or interrupt this cycle.
- event_cause  in  32  cause value.
- rec_valid  out  1  head record available.
- rec_ready  in  1  checker accepts head record.
- rec_seq  out  SEQ_W  sequence number of head record.
- rec_flags  out  4  bit0 commit, bit1 mem_valid, bit2 mem_write, bit3 event.
- rec_pc, rec_inst, rec_rd_wdata, rec_mem_addr, rec_mem_data, rec_cause  out  32 each  head record fields.
- rec_rd_addr  out  5  head record field.
- rec_mem_width  out  7  head record field.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: at least one record dropped.
- drop_count  out  SEQ_W  dropped records, saturating.
- clear_status  in  1  synchronous clear of overflow and drop_count.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty, level=0, rec_valid=0;
  - all rec_* outputs 0;
  - sequence counter 0, overflow=0, drop_count=0.
  - Reset mid-operation discards all queued records immediately.
- Push request: push_req = commit_valid | event_valid.
  - One record per cycle. Commit and event in the same cycle produce a single record with both flag bits set.
  - mem_* inputs are captured only when commit_valid=1; otherwise the mem flags and mem fields are 0.
  - When commit_valid=0, the commit fields (pc, inst, rd_addr, rd_wdata) are stored as 0.
  - rd_addr=0 forces rec_rd_wdata=0.
- Sequence counter:
  - Increments by 1 (wrapping modulo 2^SEQ_W) on every push_req, whether or not the record is accepted.
  - The record carries the pre-increment value. Drops therefore appear as gaps in rec_seq.
- Pop: occurs when rec_valid & rec_ready.
  - rec_* always show the head entry while rec_valid=1 (FWFT; zero-latency head).
  - A record pushed into an empty FIFO is visible on rec_* the following cycle (1-cycle latency).
- Full handling:
  - push_req with level=DEPTH and no pop in the same cycle: record dropped.
  - On a drop, overflow←1 and drop_count←drop_count+1, saturating at all-ones.
  - push_req with level=DEPTH and a pop in the same cycle: the record is accepted and level is unchanged.
- Empty handling:
  - rec_ready with rec_valid=0 has no effect.
  - Push into an empty FIFO and pop in the same cycle are impossible, because rec_valid=0 that cycle.
- Level update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Pointers: read and write pointers wrap modulo DEPTH.
- Handshake rules:
  - rec_valid never deasserts without a pop, except on reset.
  - Head fields are stable while rec_valid=1 and rec_ready=0.
- clear_status:
  - Clears overflow and drop_count the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- Sequential only; no combinational path from the push inputs to rec_*.

Test Plan:
- Reset, then a single commit (pc=0x80000000, inst=0x00100093, rd=1, wdata=1) with rec_ready=1.
  → Next cycle: rec_valid=1, seq=0, flags=0001, rd_addr=1, wdata=1. Following cycle: level=0.
- Commit with mem_valid=1, mem_write=1, addr=0x100, width=32, data=0xDEADBEEF, plus event_valid=1 with cause=2 in the same cycle.
  → One record: flags=1111, cause=2, mem fields match.
- rec_ready=0, 10 consecutive commits with DEPTH=8.
  → level=8, overflow=1, drop_count=2. After draining, seq values read 0..7. The next commit gets seq=10.
- FIFO full, commit and rec_ready=1 in the same cycle.
  → Record accepted, level stays 8, drop_count unchanged.
- Event only (event_valid=1, commit_valid=0) with stale mem_valid=1.
  → flags=1000, and pc/inst/rd_addr/rd_wdata/mem fields are 0.
- Reset asserted with 5 entries queued.
  → rec_valid=0 and level=0 immediately (asynchronously). The first post-reset record has seq=0.
